mem_arbiter: RTL

//  Two-client arbiter in front of the external memory port (ExtMemModel / off-chip mem).

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-client arbiter in front of the external memory port. Client 0 is the
//   dcache and client 1 is the icache. Only one transaction is in flight at a
//   time. The arbiter forwards the owner's request and write-data channels, and
//   it steers the read response beats back to the owner.
//   Requests pass through with one cycle of latency (an IDLE arbitration cycle).
//   Responses pass through with zero cycles of latency.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cX_req_*                    client request channel (valid/ready/rw/addr/tag)
//   cX_req_data_*               client write-data channel (valid/ready/bits/mask)
//   cX_resp_valid/data/tag      read beats; data/tag are a shared passthrough bus
//   mem_req_*, mem_req_data_*   request and write-data channels toward memory
//   mem_resp_valid/data/tag     read beats from memory
module mem_arbiter #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_TAG_BITS  = 5,
    parameter int READ_BEATS    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    // client 0 (dcache)
    input  logic                       c0_req_valid,
    output logic                       c0_req_ready,
    input  logic                       c0_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   c0_req_addr,
    input  logic [MEM_TAG_BITS-1:0]    c0_req_tag,
    input  logic                       c0_req_data_valid,
    output logic                       c0_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   c0_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] c0_req_data_mask,
    output logic                       c0_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   c0_resp_data,
    output logic [MEM_TAG_BITS-1:0]    c0_resp_tag,
    // client 1 (icache)
    input  logic                       c1_req_valid,
    output logic                       c1_req_ready,
    input  logic                       c1_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   c1_req_addr,
    input  logic [MEM_TAG_BITS-1:0]    c1_req_tag,
    input  logic                       c1_req_data_valid,
    output logic                       c1_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   c1_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] c1_req_data_mask,
    output logic                       c1_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   c1_resp_data,
    output logic [MEM_TAG_BITS-1:0]    c1_resp_tag,
    // memory side
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic [MEM_TAG_BITS-1:0]    mem_req_tag,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,
    input  logic [MEM_TAG_BITS-1:0]    mem_resp_tag
);

    localparam int BEAT_W = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(READ_BEATS - 1);

    typedef enum logic [1:0] {IDLE, GRANT, WR, RD} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                winner;
    logic                wdata_valid;

    // Round-robin: on contention, the client that did not win last time wins now.
    // Reset sets last=1, so client 0 wins the first contended grant.
    assign winner = (c0_req_valid && c1_req_valid) ? ~last_q : c1_req_valid;

    // The read data and tag go to both clients. Only resp_valid is steered.
    assign c0_resp_data = mem_resp_data;
    assign c0_resp_tag  = mem_resp_tag;
    assign c1_resp_data = mem_resp_data;
    assign c1_resp_tag  = mem_resp_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;

        mem_req_valid      = 1'b0;
        mem_req_rw         = owner_q ? c1_req_rw   : c0_req_rw;
        mem_req_addr       = owner_q ? c1_req_addr : c0_req_addr;
        mem_req_tag        = owner_q ? c1_req_tag  : c0_req_tag;
        wdata_valid        = 1'b0;
        mem_req_data_bits  = owner_q ? c1_req_data_bits : c0_req_data_bits;
        mem_req_data_mask  = owner_q ? c1_req_data_mask : c0_req_data_mask;
        c0_req_ready       = 1'b0;
        c1_req_ready       = 1'b0;
        c0_req_data_ready  = 1'b0;
        c1_req_data_ready  = 1'b0;
        c0_resp_valid      = 1'b0;
        c1_resp_valid      = 1'b0;

        case (state_q)
            IDLE: begin
                // Arbitrate only. Nothing is accepted in this cycle.
                if (c0_req_valid || c1_req_valid) begin
                    owner_d = winner;
                    last_d  = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                mem_req_valid = 1'b1;
                c0_req_ready  = mem_req_ready && !owner_q;
                c1_req_ready  = mem_req_ready &&  owner_q;
                if (mem_req_ready) begin
                    state_d = mem_req_rw ? WR : RD;
                    beat_d  = '0;
                end
            end
            WR: begin
                wdata_valid       = owner_q ? c1_req_data_valid : c0_req_data_valid;
                c0_req_data_ready = mem_req_data_ready && !owner_q;
                c1_req_data_ready = mem_req_data_ready &&  owner_q;
                if (wdata_valid && mem_req_data_ready) state_d = IDLE;
            end
            RD: begin
                c0_resp_valid = mem_resp_valid && !owner_q;
                c1_resp_valid = mem_resp_valid &&  owner_q;
                if (mem_resp_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        mem_req_data_valid = wdata_valid;
    end

endmodule
